i2c_mt9v034_cfg_seq: RTL

- Configuration sequencer for the MT9V034 sensor. It sits directly downstream of the sensor's register LUT.
- Drives the LUT index, registers each {addr8, data16} entry, and issues one I2C transaction per entry to the byte-level I2C master.
- The first READ_ENTRIES entries are read-and-compare checks (lock code, chip version). The remaining entries are writes.
- Reports busy/done/error to the camera capture logic.

---
 rtl/i2c_mt9v034_cfg_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/i2c_mt9v034_cfg_seq.sv
// MT9V034 configuration sequencer: walks the register LUT, issues one I2C
// transaction per entry (read-checks first, then writes) and reports status.
module i2c_mt9v034_cfg_seq #(
    parameter logic [19:0] PWR_DLY      = 20'd1000000,
    parameter logic [15:0] GAP_CYCLES   = 16'd1000,
    parameter logic [7:0]  READ_ENTRIES = 8'd2,
    parameter logic [2:0]  MAX_RETRY    = 3'd3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_restart,
    output logic [7:0]  lut_index,
    input  logic [23:0] lut_data,
    input  logic [7:0]  lut_size,
    output logic        txn_req,
    output logic        txn_rw,
    output logic [7:0]  txn_addr,
    output logic [15:0] txn_wdata,
    input  logic        txn_done,
    input  logic        txn_nack,
    input  logic [15:0] txn_rdata,
    output logic        cfg_busy,
    output logic        cfg_done,
    output logic        cfg_err,
    output logic        cfg_id_err
);

    typedef enum logic [2:0] {
        PWRUP, FETCH, REQ, WAIT, GAP, DONE, ERR
    } state_t;

    localparam logic [19:0] GAP_EXT = {4'd0, GAP_CYCLES};

    state_t      state;
    logic [19:0] cnt;
    logic [2:0]  retry_cnt;
    logic        pwr_last;
    logic        gap_last;

    assign pwr_last = (cnt + 20'd1 >= PWR_DLY);
    assign gap_last = (cnt + 20'd1 >= GAP_EXT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= PWRUP;
            cnt        <= '0;
            retry_cnt  <= '0;
            lut_index  <= '0;
            txn_req    <= 1'b0;
            txn_rw     <= 1'b0;
            txn_addr   <= '0;
            txn_wdata  <= '0;
            cfg_busy   <= 1'b1;
            cfg_done   <= 1'b0;
            cfg_err    <= 1'b0;
            cfg_id_err <= 1'b0;
        end else begin
            case (state)
                PWRUP: begin
                    if (pwr_last) begin
                        cnt   <= '0;
                        state <= (lut_size == 8'd0) ? DONE : FETCH;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                FETCH: begin
                    // txn_req is raised here so it is already high during REQ
                    txn_addr  <= lut_data[23:16];
                    txn_wdata <= lut_data[15:0];
                    txn_rw    <= (lut_index < READ_ENTRIES);
                    txn_req   <= 1'b1;
                    state     <= REQ;
                end
                REQ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (txn_done && txn_req) begin
                        txn_req <= 1'b0;
                        if (txn_nack) begin
                            if (retry_cnt < MAX_RETRY) begin
                                retry_cnt <= retry_cnt + 3'd1;
                                state     <= GAP;
                            end else begin
                                state <= ERR;
                            end
                        end else begin
                            if (txn_rw && (txn_rdata != txn_wdata))
                                cfg_id_err <= 1'b1;
                            retry_cnt <= '0;
                            lut_index <= lut_index + 8'd1;
                            state     <= GAP;
                        end
                    end
                end
                GAP: begin
                    // a NACK retry lands back in FETCH with the index unchanged
                    if (gap_last) begin
                        cnt   <= '0;
                        state <= (lut_index >= lut_size) ? DONE : FETCH;
                    end else begin
                        cnt <= cnt + 20'd1;
                    end
                end
                DONE, ERR: begin
                    cfg_busy <= 1'b0;
                    if (state == DONE) cfg_done <= 1'b1;
                    else               cfg_err  <= 1'b1;
                    if (cfg_restart) begin
                        cfg_busy   <= 1'b1;
                        cfg_done   <= 1'b0;
                        cfg_err    <= 1'b0;
                        cfg_id_err <= 1'b0;
                        retry_cnt  <= '0;
                        lut_index  <= '0;
                        cnt        <= '0;
                        state      <= FETCH;
                    end
                end
                default: begin
                    state <= PWRUP;
                end
            endcase
        end
    end

endmodule
